// File: rtl/register_file_write_controller.sv
// Single write port of the register file, shared by a burst host loader, compute writeback and a clear sweep.
// Writes appear on rf_write_* one cycle after their handshake; clear back-pressures both requesters, streaming round-robins them.
module register_file_write_controller #(
    parameter int NUMBER_OF_REGISTERS = 256,
    localparam int ADDR_W = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    input  logic              clear_start_in,
    input  logic              host_start_in,
    input  logic [ADDR_W-1:0] host_base_address_in,
    input  logic [ADDR_W:0]   host_length_in,
    input  logic              host_valid_in,
    input  logic [7:0]        host_data_in,
    output logic              host_ready_out,
    output logic              host_done_out,
    input  logic              wb_valid_in,
    input  logic [ADDR_W-1:0] wb_address_in,
    input  logic [7:0]        wb_data_in,
    output logic              wb_ready_out,
    output logic              rf_write_enable_out,
    output logic [ADDR_W-1:0] rf_write_address_out,
    output logic [7:0]        rf_write_data_out,
    output logic              busy_out
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUMBER_OF_REGISTERS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_host;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_length;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_sweep;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_data;
    logic                r_done;

    logic                w_host_ready;
    logic                w_wb_ready;
    logic                w_host_fire;
    logic                w_wb_fire;
    logic [ADDR_W:0]     w_count_next;
    logic [ADDR_W-1:0]   w_host_addr;
    logic                w_burst_end;
    logic                w_zero_len;

    // The losing side of a contested cycle is the one that was granted last.
    assign w_host_ready = (r_state == S_STREAM) && (!wb_valid_in || !r_last_host);
    assign w_wb_ready   = (r_state == S_IDLE) ||
                          ((r_state == S_STREAM) && (!host_valid_in || r_last_host));
    assign w_host_fire  = host_valid_in && w_host_ready;
    assign w_wb_fire    = wb_valid_in && w_wb_ready;
    assign w_count_next = r_count + {{ADDR_W{1'b0}}, 1'b1};
    assign w_host_addr  = r_base + r_count[ADDR_W-1:0];
    assign w_burst_end  = w_host_fire && (w_count_next == r_length);
    assign w_zero_len   = (r_state == S_IDLE) && !clear_start_in && host_start_in &&
                          (host_length_in == '0);

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear_start_in) begin
                    w_next_state = S_CLEAR;
                end else if (host_start_in && (host_length_in != '0)) begin
                    w_next_state = S_STREAM;
                end
            end
            S_CLEAR: begin
                if (r_sweep == LAST_ADDR) begin
                    w_next_state = S_IDLE;
                end
            end
            S_STREAM: begin
                if (w_burst_end) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_last_host <= 1'b0;
            r_count     <= '0;
            r_length    <= '0;
            r_base      <= '0;
            r_sweep     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= w_burst_end || w_zero_len;
            if (r_state == S_IDLE) begin
                if (clear_start_in) begin
                    r_sweep <= '0;
                end else if (host_start_in && (host_length_in != '0)) begin
                    r_base   <= host_base_address_in;
                    r_length <= host_length_in;
                    r_count  <= '0;
                end
            end
            // Address and data only move on a write so they hold otherwise.
            if (r_state == S_CLEAR) begin
                r_we    <= 1'b1;
                r_addr  <= r_sweep;
                r_data  <= 8'h00;
                r_sweep <= r_sweep + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else if (w_host_fire) begin
                r_we        <= 1'b1;
                r_addr      <= w_host_addr;
                r_data      <= host_data_in;
                r_count     <= w_count_next;
                r_last_host <= 1'b1;
            end else if (w_wb_fire) begin
                r_we        <= 1'b1;
                r_addr      <= wb_address_in;
                r_data      <= wb_data_in;
                r_last_host <= 1'b0;
            end
        end
    end

    assign host_ready_out       = w_host_ready;
    assign wb_ready_out         = w_wb_ready;
    assign host_done_out        = r_done;
    assign rf_write_enable_out  = r_we;
    assign rf_write_address_out = r_addr;
    assign rf_write_data_out    = r_data;
    assign busy_out             = (r_state != S_IDLE);
endmodule

// File: tb/tb_register_file_write_controller.sv
// Randomised and directed stimulus against a queue-based reference model of the write controller.
module tb_register_file_write_controller;
    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_start = 1'b0;
    logic       host_start = 1'b0;
    logic [7:0] host_base = '0;
    logic [8:0] host_len = '0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = '0;
    logic       host_ready;
    logic       host_done;
    logic       wb_valid = 1'b0;
    logic [7:0] wb_addr = '0;
    logic [7:0] wb_data = '0;
    logic       wb_ready;
    logic       rf_we;
    logic [7:0] rf_addr;
    logic [7:0] rf_data;
    logic       busy;

    register_file_write_controller #(.NUMBER_OF_REGISTERS(N)) dut (
        .clock_in             (clk),
        .reset_n_in           (rst_n),
        .clear_start_in       (clear_start),
        .host_start_in        (host_start),
        .host_base_address_in (host_base),
        .host_length_in       (host_len),
        .host_valid_in        (host_valid),
        .host_data_in         (host_data),
        .host_ready_out       (host_ready),
        .host_done_out        (host_done),
        .wb_valid_in          (wb_valid),
        .wb_address_in        (wb_addr),
        .wb_data_in           (wb_data),
        .wb_ready_out         (wb_ready),
        .rf_write_enable_out  (rf_we),
        .rf_write_address_out (rf_addr),
        .rf_write_data_out    (rf_data),
        .busy_out             (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       done;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    bit   drv_done = 1'b0;

    // Reference model: what mode the block is in and what the burst still owes.
    int   m_mode = 0;      // 0 idle, 1 clearing, 2 streaming
    int   m_next_addr = 0;
    int   m_left = 0;
    int   m_sweep = 0;
    bit   m_last_host = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    endtask

    task automatic push_idle_entry();
        exp_t e;
        e = '0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_start = 1'b0; host_start = 1'b0; host_valid = 1'b0; wb_valid = 1'b0;
        #1;
        chk("reset_we", int'(rf_we), 0);
        chk("reset_addr", int'(rf_addr), 0);
        chk("reset_data", int'(rf_data), 0);
        chk("reset_done", int'(host_done), 0);
        chk("reset_busy", int'(busy), 0);
        m_mode = 0; m_last_host = 1'b0; m_left = 0;
        push_idle_entry();
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            push_idle_entry();
        end
    endtask

    task automatic cycle(input bit cs, input bit hs, input int base, input int len,
                         input bit hv, input int hd, input bit wv, input int wa, input int wd);
        bit   exp_hr, exp_wr, hf, wf;
        int   prev_mode;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        clear_start = cs; host_start = hs;
        host_base = 8'(base); host_len = 9'(len);
        host_valid = hv; host_data = 8'(hd);
        wb_valid = wv; wb_addr = 8'(wa); wb_data = 8'(wd);
        #1;
        exp_hr = (m_mode == 2) && (!wv || !m_last_host);
        exp_wr = (m_mode == 0) || ((m_mode == 2) && (!hv || m_last_host));
        chk("host_ready", int'(host_ready), int'(exp_hr));
        chk("wb_ready", int'(wb_ready), int'(exp_wr));
        e = '0;
        prev_mode = m_mode;
        if (m_mode == 1) begin
            e.we = 1'b1; e.addr = 8'(m_sweep); e.data = 8'h00;
            m_sweep++;
            if (m_sweep == N) m_mode = 0;
        end else begin
            hf = hv && exp_hr;
            wf = wv && exp_wr;
            if (hf) begin
                e.we = 1'b1; e.addr = 8'(m_next_addr); e.data = 8'(hd);
                m_next_addr = (m_next_addr + 1) % N;
                m_last_host = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    e.done = 1'b1;
                    m_mode = 0;
                end
            end else if (wf) begin
                e.we = 1'b1; e.addr = 8'(wa); e.data = 8'(wd);
                m_last_host = 1'b0;
            end
        end
        if (prev_mode == 0) begin
            if (cs) begin
                m_mode = 1; m_sweep = 0;
            end else if (hs) begin
                if (len > 0) begin
                    m_mode = 2; m_next_addr = base; m_left = len;
                end else begin
                    e.done = 1'b1;
                end
            end
        end
        e.busy = (m_mode != 0);
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin
        exp_t e;
        wait (mon_en);
        while (!drv_done || exp_q.size() != 0) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                if (!drv_done) chk("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_enable", int'(rf_we), int'(e.we));
                if (e.we) begin
                    chk("wr_addr", int'(rf_addr), int'(e.addr));
                    chk("wr_data", int'(rf_data), int'(e.data));
                end
                chk("host_done", int'(host_done), int'(e.done));
                chk("busy", int'(busy), int'(e.busy));
            end
        end
    end

    initial begin
        do_reset();
        idle_cycles(2);

        // Burst interrupted by reset: nothing further may be written.
        cycle(0, 1, 'h10, 4, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 'h11, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 'h22, 0, 0, 0);
        do_reset();
        idle_cycles(4);

        // Host burst wrapping past the top address.
        cycle(0, 1, 'hFE, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 'hA1 + i, 0, 0, 0);
        idle_cycles(3);

        // Contention: both requesters valid continuously.
        cycle(0, 1, 'h20, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0, 1, 'hC0 + i, 1, 'h40, 'h55);
        idle_cycles(2);

        // Clear sweep with writeback held valid throughout.
        cycle(1, 0, 0, 0, 0, 0, 1, 'h33, 'h77);
        for (int i = 0; i < 262; i++) cycle(0, 0, 0, 0, 0, 0, 1, 'h33, 'h78);
        idle_cycles(2);

        // Clear and host start together: clear wins.
        cycle(1, 1, 'h50, 5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) cycle(0, 0, 0, 0, 1, i, 0, 0, 0);

        // Zero-length burst.
        cycle(0, 1, 'h07, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);

        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom % 600) == 0, ($urandom % 6) == 0, int'($urandom % N),
                  (($urandom % 40) == 0) ? N : int'($urandom_range(0, 12)),
                  ($urandom % 4) != 0, int'($urandom % 256),
                  ($urandom % 3) == 0, int'($urandom % N), int'($urandom % 256));
        end
        for (int i = 0; i < 300; i++) cycle(0, 0, 0, 0, 1, int'($urandom % 256), 0, 0, 0);

        drv_done = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
